// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two requesters, with a fill sweeper.
// Define RAM_ARB_STATS_EN to add saturating grant/conflict counters.
module ram_port_arbiter #(
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter int unsigned           DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0]              req_we,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    input  logic                    init_start,
    output logic                    init_busy,
    output logic                    init_done,
    output logic                    ram_wr_en,
    output logic [ADDR_WIDTH-1:0]   ram_wr_addr,
    output logic [ADDR_WIDTH-1:0]   ram_rd_addr,
    output logic [DATA_WIDTH-1:0]   ram_wr_data,
    input  logic [DATA_WIDTH-1:0]   ram_rd_data
`ifdef RAM_ARB_STATS_EN
    ,
    output logic [15:0]             grant_cnt0,
    output logic [15:0]             grant_cnt1,
    output logic [15:0]             conflict_cnt
`endif
);

    typedef enum logic {
        ST_RUN,
        ST_INIT
    } state_e;

    // Sweep counter is one bit wider than the address; only the terminal value ends the sweep.
    localparam logic [ADDR_WIDTH:0] CNT_LAST = {1'b0, {ADDR_WIDTH{1'b1}}};

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
    logic                    rr_last_q, rr_last_d;
    logic [1:0]              rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic                    init_done_q, init_done_d;

    logic                    grant_any;
    logic                    grant_idx;
    logic                    win_we;
    logic [ADDR_WIDTH-1:0]   win_addr;
    logic [DATA_WIDTH-1:0]   win_wdata;

    assign win_we    = req_we[grant_idx];
    assign win_addr  = grant_idx ? req_addr[ADDR_WIDTH +: ADDR_WIDTH] : req_addr[0 +: ADDR_WIDTH];
    assign win_wdata = grant_idx ? req_wdata[DATA_WIDTH +: DATA_WIDTH] : req_wdata[0 +: DATA_WIDTH];

    // Grants only in RUN and never in the cycle that accepts init_start.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = 1'b0;
        if (state_q == ST_RUN && !init_start) begin
            unique case (req_valid)
                2'b01:   begin grant_any = 1'b1; grant_idx = 1'b0;       end
                2'b10:   begin grant_any = 1'b1; grant_idx = 1'b1;       end
                2'b11:   begin grant_any = 1'b1; grant_idx = !rr_last_q; end
                default: begin grant_any = 1'b0; grant_idx = 1'b0;       end
            endcase
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_last_d   = rr_last_q;
        rsp_valid_d = 2'b00;
        rsp_data_d  = rsp_data_q;
        init_done_d = 1'b0;
        req_ready   = 2'b00;
        ram_wr_en   = 1'b0;
        ram_wr_addr = win_addr;
        ram_rd_addr = req_addr[0 +: ADDR_WIDTH];
        ram_wr_data = win_wdata;

        unique case (state_q)
            ST_RUN: begin
                if (init_start) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end else if (grant_any) begin
                    req_ready[grant_idx] = 1'b1;
                    rr_last_d            = grant_idx;
                    if (win_we) begin
                        ram_wr_en = 1'b1;
                    end else begin
                        ram_rd_addr              = win_addr;
                        rsp_valid_d[grant_idx]   = 1'b1;
                        rsp_data_d               = ram_rd_data;
                    end
                end
            end
            ST_INIT: begin
                ram_wr_en   = 1'b1;
                ram_wr_addr = cnt_q[ADDR_WIDTH-1:0];
                ram_rd_addr = cnt_q[ADDR_WIDTH-1:0];
                ram_wr_data = INIT_VALUE;
                if (cnt_q == CNT_LAST) begin
                    state_d     = ST_RUN;
                    cnt_d       = '0;
                    init_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: only control state is reset here; the RAM contents are deliberately left alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            rr_last_q   <= 1'b1;
            rsp_valid_q <= 2'b00;
            rsp_data_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_last_q   <= rr_last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            init_done_q <= init_done_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign init_busy = (state_q == ST_INIT);
    assign init_done = init_done_q;

`ifdef RAM_ARB_STATS_EN
    logic        start_accept;
    logic [15:0] grant_cnt0_q, grant_cnt1_q, conflict_cnt_q;

    assign start_accept = (state_q == ST_RUN) && init_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0_q   <= '0;
            grant_cnt1_q   <= '0;
            conflict_cnt_q <= '0;
        end else if (start_accept) begin
            grant_cnt0_q   <= '0;
            grant_cnt1_q   <= '0;
            conflict_cnt_q <= '0;
        end else begin
            if (grant_any && !grant_idx && grant_cnt0_q != 16'hFFFF)
                grant_cnt0_q <= grant_cnt0_q + 16'd1;
            if (grant_any && grant_idx && grant_cnt1_q != 16'hFFFF)
                grant_cnt1_q <= grant_cnt1_q + 16'd1;
            if (state_q == ST_RUN && &req_valid && conflict_cnt_q != 16'hFFFF)
                conflict_cnt_q <= conflict_cnt_q + 16'd1;
        end
    end

    assign grant_cnt0   = grant_cnt0_q;
    assign grant_cnt1   = grant_cnt1_q;
    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule
